// File: rtl/sys_defs_pkg.sv
//==============================================================================
// Module      : sys_defs (package)
// Description : Shared completion-packet type and functional-unit indices.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package sys_defs;

    localparam int ALU_1  = 0;
    localparam int ALU_2  = 1;
    localparam int ALU_3  = 2;
    localparam int MULT_1 = 3;
    localparam int MULT_2 = 4;
    localparam int BRANCH = 5;

    localparam int PR_IDX_W  = 6;
    localparam int ROB_IDX_W = 5;
    localparam int XLEN      = 32;

    typedef struct packed {
        logic [PR_IDX_W-1:0]  pr_idx;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [XLEN-1:0]      result;
        logic                 branch_taken;
    } FU_COMPLETE_PACKET;

    // Index width that stays legal for a single-entry vector.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/complete_arbiter_picker.sv
//==============================================================================
// Module      : rr_multi_picker
// Description : Rotating scan that grants up to NUM_GNT requesters per cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_multi_picker
    import sys_defs::*;
#(
    parameter int NUM_REQ = 6,
    parameter int NUM_GNT = 2,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [PTR_W-1:0]                start_i,
    output logic [NUM_GNT-1:0][NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]                last_o,
    output logic                            any_o
);

    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_idx;
    int               w_cnt;

    // The n-th request found from start_i lands on port n.
    always_comb begin
        grant_o = '0;
        last_o  = start_i;
        any_o   = 1'b0;
        w_cnt   = 0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, start_i} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
            end
            w_idx = w_sum[PTR_W-1:0];
            if (req_i[w_idx] && (w_cnt < NUM_GNT)) begin
                for (int p = 0; p < NUM_GNT; p++) begin
                    if (w_cnt == p) begin
                        grant_o[p][w_idx] = 1'b1;
                    end
                end
                last_o = w_idx;
                any_o  = 1'b1;
                w_cnt  = w_cnt + 1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/complete_arbiter.sv
//==============================================================================
// Module      : complete_arbiter
// Description : Buffers one completion per FU and broadcasts up to NUM_CDB per cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module complete_arbiter
    import sys_defs::*;
#(
    parameter int  NUM_FU  = 6,
    parameter int  NUM_CDB = 2,
    localparam int PTR_W   = ptr_width(NUM_FU)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_FU-1:0] fu_valid,
    input  FU_COMPLETE_PACKET fu_packet_in [NUM_FU],
    input  logic              squash,
    output logic [NUM_FU-1:0] fu_ready,
    output logic [NUM_CDB-1:0] cdb_valid,
    output FU_COMPLETE_PACKET cdb_packet [NUM_CDB],
    output logic [NUM_FU-1:0] fu_free,
    output logic [PTR_W-1:0]  rr_ptr_out
);

    logic [NUM_FU-1:0]  hold_valid_q;
    logic [NUM_FU-1:0]  hold_valid_d;
    FU_COMPLETE_PACKET  hold_packet_q [NUM_FU];
    FU_COMPLETE_PACKET  hold_packet_d [NUM_FU];
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   rr_ptr_d;

    logic [NUM_FU-1:0]               w_req;
    logic [NUM_CDB-1:0][NUM_FU-1:0]  w_grant;
    logic [PTR_W-1:0]                w_last;
    logic                            w_any;

    // Squash hides every slot from the picker, which silences all grants.
    assign w_req = hold_valid_q & {NUM_FU{~squash}};

    rr_multi_picker #(
        .NUM_REQ (NUM_FU),
        .NUM_GNT (NUM_CDB),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req_i   (w_req),
        .start_i (rr_ptr_q),
        .grant_o (w_grant),
        .last_o  (w_last),
        .any_o   (w_any)
    );

    always_comb begin
        fu_free = '0;
        for (int p = 0; p < NUM_CDB; p++) begin
            fu_free      = fu_free | w_grant[p];
            cdb_valid[p] = |w_grant[p];
            cdb_packet[p] = '0;
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_grant[p][i]) begin
                    cdb_packet[p] = hold_packet_q[i];
                end
            end
        end
        // A slot draining this cycle can accept its replacement at the same edge.
        fu_ready   = (~hold_valid_q | fu_free) & {NUM_FU{~squash}};
        rr_ptr_out = rr_ptr_q;
    end

    always_comb begin
        hold_valid_d  = hold_valid_q;
        hold_packet_d = hold_packet_q;
        rr_ptr_d      = rr_ptr_q;
        if (squash) begin
            hold_valid_d = '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_free[i]) begin
                    hold_valid_d[i] = 1'b0;
                end
                if (fu_valid[i] && fu_ready[i]) begin
                    hold_valid_d[i]  = 1'b1;
                    hold_packet_d[i] = fu_packet_in[i];
                end
            end
            if (w_any) begin
                rr_ptr_d = (w_last == PTR_W'(NUM_FU-1)) ? '0 : w_last + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_valid_q <= '0;
            rr_ptr_q     <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                hold_packet_q[i] <= '0;
            end
        end else begin
            hold_valid_q <= hold_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            for (int i = 0; i < NUM_FU; i++) begin
                hold_packet_q[i] <= hold_packet_d[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_complete_arbiter.sv
//==============================================================================
// Module      : tb_complete_arbiter
// Description : Directed bench with a queue-based completion model for complete_arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_complete_arbiter;
    import sys_defs::*;

    localparam int N    = 6;
    localparam int C    = 2;
    localparam int PW   = 3;
    localparam int FAIR = (N + C - 1) / C;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              squash = 1'b0;
    logic [N-1:0]      fu_valid = '0;
    FU_COMPLETE_PACKET fu_packet_in [N];
    logic [N-1:0]      fu_ready;
    logic [C-1:0]      cdb_valid;
    FU_COMPLETE_PACKET cdb_packet [C];
    logic [N-1:0]      fu_free;
    logic [PW-1:0]     rr_ptr_out;

    complete_arbiter #(.NUM_FU(N), .NUM_CDB(C)) dut (
        .clock        (clock),
        .reset        (reset),
        .fu_valid     (fu_valid),
        .fu_packet_in (fu_packet_in),
        .squash       (squash),
        .fu_ready     (fu_ready),
        .cdb_valid    (cdb_valid),
        .cdb_packet   (cdb_packet),
        .fu_free      (fu_free),
        .rr_ptr_out   (rr_ptr_out)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic FU_COMPLETE_PACKET mkpkt(input int pr);
        FU_COMPLETE_PACKET p;
        p.pr_idx       = PR_IDX_W'(pr);
        p.rob_idx      = ROB_IDX_W'(pr + 3);
        p.result       = 32'hC0DE_0000 | 32'(pr);
        p.branch_taken = pr[0];
        return p;
    endfunction

    // Model: a slot per FU plus a scan start; winners are the first C held slots from the start.
    bit                m_hv [N];
    FU_COMPLETE_PACKET m_hp [N];
    int                m_ptr = 0;
    bit                n_hv [N];
    FU_COMPLETE_PACKET n_hp [N];
    int                n_ptr = 0;
    int                wait_cnt [N];
    bit                log_en = 1'b0;
    int                fu0_log [$];

    always @(negedge clock) begin
        int win [$];
        logic [N-1:0] e_free;
        logic [N-1:0] e_ready;
        FU_COMPLETE_PACKET e_pkt;
        win = {};
        if (!squash) begin
            for (int k = 0; k < N; k++) begin
                if (m_hv[(m_ptr + k) % N] && win.size() < C) win.push_back((m_ptr + k) % N);
            end
        end
        e_free = '0;
        foreach (win[j]) e_free[win[j]] = 1'b1;
        for (int i = 0; i < N; i++) e_ready[i] = !squash && (!m_hv[i] || e_free[i]);
        check("fu_ready", 64'(fu_ready), 64'(e_ready));
        check("fu_free", 64'(fu_free), 64'(e_free));
        check("rr_ptr_out", 64'(rr_ptr_out), 64'(m_ptr));
        for (int p = 0; p < C; p++) begin
            e_pkt = '0;
            if (p < win.size()) e_pkt = m_hp[win[p]];
            check("cdb_valid", 64'(cdb_valid[p]), 64'(p < win.size()));
            check("cdb_packet", 64'(cdb_packet[p]), 64'(e_pkt));
            if (log_en && cdb_valid[p] && cdb_packet[p].pr_idx >= 20 && cdb_packet[p].pr_idx < 40)
                fu0_log.push_back(int'(cdb_packet[p].pr_idx));
        end
        for (int i = 0; i < N; i++) begin
            if (m_hv[i] && !squash && !reset && !e_free[i]) begin
                wait_cnt[i]++;
                checks++;
                if (wait_cnt[i] >= FAIR) begin
                    failures++;
                    $display("FAIL fairness slot=%0d waited=%0d limit=%0d", i, wait_cnt[i], FAIR - 1);
                end
            end else begin
                wait_cnt[i] = 0;
            end
        end
        n_hv = m_hv; n_hp = m_hp; n_ptr = m_ptr;
        if (reset) begin
            for (int i = 0; i < N; i++) begin n_hv[i] = 1'b0; n_hp[i] = '0; end
            n_ptr = 0;
        end else if (squash) begin
            for (int i = 0; i < N; i++) n_hv[i] = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (e_free[i]) n_hv[i] = 1'b0;
                if (fu_valid[i] && e_ready[i]) begin n_hv[i] = 1'b1; n_hp[i] = fu_packet_in[i]; end
            end
            if (win.size() > 0) n_ptr = (win[win.size()-1] + 1) % N;
        end
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin m_hv[i] = 1'b0; m_hp[i] = '0; wait_cnt[i] = 0; end
            m_ptr = 0;
        end else begin
            m_hv = n_hv; m_hp = n_hp; m_ptr = n_ptr;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; fu_valid = '0; squash = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int seq;
        logic acc;
        logic [N-1:0] vec [8];
        logic         sq  [8];
        for (int i = 0; i < N; i++) fu_packet_in[i] = '0;
        #1;
        do_reset();

        // Reset state
        check("rst_fu_ready", 64'(fu_ready), 64'h3F);
        check("rst_cdb_valid", 64'(cdb_valid), 64'h0);
        check("rst_rr_ptr", 64'(rr_ptr_out), 64'h0);
        check("rst_fu_free", 64'(fu_free), 64'h0);

        // Single completion from ALU_3
        fu_valid = 6'b000100; fu_packet_in[ALU_3] = mkpkt(7);
        #1 check("lat_same_cycle", 64'(cdb_valid), 64'h0);
        step(); fu_valid = '0;
        #1;
        check("single_cdb_valid", 64'(cdb_valid), 64'h1);
        check("single_pr_idx", 64'(cdb_packet[0].pr_idx), 64'd7);
        check("single_fu_free", 64'(fu_free), 64'h04);
        check("single_port1_zero", 64'(cdb_packet[1]), 64'h0);
        step();
        check("single_rr_ptr", 64'(rr_ptr_out), 64'd3);
        check("single_drained", 64'(cdb_valid), 64'h0);

        // All six at once from pointer 0
        do_reset();
        for (int i = 0; i < N; i++) fu_packet_in[i] = mkpkt(10 + i);
        fu_valid = '1;
        step(); fu_valid = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("all6_rr_ptr", 64'(rr_ptr_out), 64'((2 * c) % 6));
            check("all6_cdb_valid", 64'(cdb_valid), 64'h3);
            check("all6_fu_free", 64'(fu_free), 64'(6'b000011) << (2 * c));
            check("all6_pr0", 64'(cdb_packet[0].pr_idx), 64'(10 + 2 * c));
            check("all6_pr1", 64'(cdb_packet[1].pr_idx), 64'(11 + 2 * c));
            step();
        end
        check("all6_rr_wrap", 64'(rr_ptr_out), 64'h0);
        check("all6_empty", 64'(cdb_valid), 64'h0);

        // ALU_1 streams while the other slots start full
        do_reset();
        for (int i = 1; i < N; i++) fu_packet_in[i] = mkpkt(i);
        fu_packet_in[0] = mkpkt(20);
        fu_valid = '1; seq = 0; log_en = 1'b1; fu0_log = {};
        for (int cyc = 0; cyc < 60 && seq < 10; cyc++) begin
            @(negedge clock);
            acc = fu_ready[0] && fu_valid[0];
            step();
            fu_valid[N-1:1] = '0;
            if (acc) begin
                seq++;
                if (seq < 10) fu_packet_in[0] = mkpkt(20 + seq);
                else fu_valid[0] = 1'b0;
            end
        end
        check("stream_accepted", 64'(seq), 64'd10);
        repeat (8) step();
        log_en = 1'b0;
        check("stream_count", 64'(fu0_log.size()), 64'd10);
        foreach (fu0_log[j]) check("stream_order", 64'(fu0_log[j]), 64'(20 + j));

        // Squash with four held
        do_reset();
        for (int i = 0; i < 4; i++) fu_packet_in[i] = mkpkt(40 + i);
        fu_valid = 6'b001111;
        step();
        squash = 1'b1; fu_valid = 6'b000001; fu_packet_in[0] = mkpkt(50);
        #1;
        check("squash_cdb_valid", 64'(cdb_valid), 64'h0);
        check("squash_fu_ready", 64'(fu_ready), 64'h0);
        check("squash_fu_free", 64'(fu_free), 64'h0);
        step(); squash = 1'b0; fu_valid = '0;
        #1;
        check("post_squash_cdb", 64'(cdb_valid), 64'h0);
        check("post_squash_ready", 64'(fu_ready), 64'h3F);
        check("post_squash_rr", 64'(rr_ptr_out), 64'h0);

        // Asynchronous reset between edges
        do_reset();
        for (int i = 0; i < 3; i++) fu_packet_in[i] = mkpkt(60 + i);
        fu_valid = 6'b000111;
        step(); fu_valid = '0;
        #1 check("pre_areset_cdb", 64'(cdb_valid), 64'h3);
        #1 reset = 1'b1;
        #1;
        check("areset_fu_ready", 64'(fu_ready), 64'h3F);
        check("areset_cdb_valid", 64'(cdb_valid), 64'h0);
        check("areset_rr_ptr", 64'(rr_ptr_out), 64'h0);
        check("areset_fu_free", 64'(fu_free), 64'h0);
        check("areset_pkt0", 64'(cdb_packet[0]), 64'h0);
        step(); reset = 1'b0;

        // Mixed patterns checked against the model
        vec[0] = 6'b101010; sq[0] = 1'b0;
        vec[1] = 6'b010101; sq[1] = 1'b0;
        vec[2] = 6'b111000; sq[2] = 1'b0;
        vec[3] = 6'b000111; sq[3] = 1'b1;
        vec[4] = 6'b100001; sq[4] = 1'b0;
        vec[5] = 6'b011110; sq[5] = 1'b0;
        vec[6] = 6'b000000; sq[6] = 1'b0;
        vec[7] = 6'b111111; sq[7] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) fu_packet_in[i] = mkpkt((k * 6 + i) % 64);
            fu_valid = vec[k]; squash = sq[k];
            step();
        end
        fu_valid = '0; squash = 1'b0;
        repeat (5) step();
        check("final_drained", 64'(cdb_valid), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
